div_ctrl: RTL and testbench

Runtime-configurable clock-divider controller for the BPSK/ConvCode datapath. It accepts divide ratio and duty settings over a valid/ready handshake and validates them. New settings are applied only at a period boundary, so div_sig never glitches. It also sequences start/stop so that every period finishes cleanly. Downstream symbol and bit-rate logic consume div_sig and the period-start strobe tick_sig.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_period_cnt.sv | 57 +++++
 rtl/div_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_div_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the div_ctrl clock-divider controller.
//   - div_state_e : controller state encoding (IDLE / RUN / PEND / STOP)
//   - MIN_NUM     : smallest divide ratio that still yields a real period
//   - DEF_NUM     : divide ratio loaded at reset
//   - DEF_DUTY    : high-cycle count loaded at reset (2/4 = 50 %)
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } div_state_e;

    localparam int MIN_NUM  = 2;
    localparam int DEF_NUM  = 4;
    localparam int DEF_DUTY = 2;

endpackage

// File: rtl/div_period_cnt.sv
// -----------------------------------------------------------------------------
// div_period_cnt
// Loadable modulo counter that sequences one divider period.
// Ports:
//   clk_sig   in   system clock
//   reset_sig in   synchronous active-high reset
//   run       in   advance the counter this cycle
//   load      in   force the counter back to 0 (wins over run)
//   num       in   modulus; the counter runs 0..num-1
//   cnt       out  current count
//   wrap      out  high on the last cycle of a period (cnt == num-1 while running)
// -----------------------------------------------------------------------------
module div_period_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] num,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);
    import div_pkg::*;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap detection and next count value.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = run && !load && (cnt_q == (num - {{(CNT_W-1){1'b0}}, 1'b1}));
        if (load) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (run) begin
            if (wrap) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Runtime-configurable clock divider. Ratio/duty arrive over a valid/ready
// handshake, are validated, and only take effect at a period boundary so
// div_sig never glitches. Start/stop is sequenced so every period completes.
// Ports:
//   clk_sig        in   system clock
//   reset_sig      in   synchronous active-high reset
//   en_sig         in   run request (level)
//   cfg_valid_sig  in   config offer
//   cfg_ready_sig  out  config can be accepted (low only while a config is pending)
//   cfg_num_sig    in   requested divide ratio
//   cfg_duty_sig   in   requested high cycles per period
//   div_sig        out  divided output (registered)
//   tick_sig       out  one-cycle pulse at the start of each period (registered)
//   cfg_err_sig    out  one-cycle pulse: offered config rejected
//   pend_sig       out  accepted config waiting for the next boundary
//   active_num_sig out  divide ratio currently in use
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_NUM  = div_pkg::DEF_NUM,
    parameter int DEF_DUTY = div_pkg::DEF_DUTY
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             en_sig,
    input  logic             cfg_valid_sig,
    output logic             cfg_ready_sig,
    input  logic [CNT_W-1:0] cfg_num_sig,
    input  logic [CNT_W-1:0] cfg_duty_sig,
    output logic             div_sig,
    output logic             tick_sig,
    output logic             cfg_err_sig,
    output logic             pend_sig,
    output logic [CNT_W-1:0] active_num_sig
);
    import div_pkg::*;

    // A config is usable when it has at least two cycles per period and the
    // high time fits inside the period.
    function automatic logic cfg_legal(input logic [CNT_W-1:0] num,
                                       input logic [CNT_W-1:0] duty);
        return (num >= CNT_W'(MIN_NUM)) && (duty <= num);
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] num_act_q, num_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] shd_num_q, shd_num_d;
    logic [CNT_W-1:0] shd_duty_q, shd_duty_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt_s;
    logic             wrap_s;
    logic             running_s;
    logic             xfer_s;
    logic             legal_s;

    assign running_s = (state_q != ST_IDLE);
    assign xfer_s    = cfg_valid_sig && !pend_q;
    assign legal_s   = cfg_legal(cfg_num_sig, cfg_duty_sig);

    // Counter is held at 0 while idle so the first running cycle is cnt == 0.
    div_period_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .run       (running_s),
        .load      (!running_s),
        .num       (num_act_q),
        .cnt       (cnt_s),
        .wrap      (wrap_s)
    );

    // Config apply rules, next state and next outputs.
    always_comb begin
        state_d    = state_q;
        num_act_d  = num_act_q;
        duty_act_d = duty_act_q;
        shd_num_d  = shd_num_q;
        shd_duty_d = shd_duty_q;
        pend_d     = pend_q;
        err_d      = 1'b0;
        div_d      = running_s && (cnt_s < duty_act_q);
        tick_d     = running_s && (cnt_s == {CNT_W{1'b0}});

        // A rejected offer is still consumed; it only raises the error pulse.
        if (xfer_s && !legal_s) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end

        if (!running_s) begin
            // Idle: no period in flight, so a legal config applies at once.
            if (xfer_s && legal_s) begin
                num_act_d  = cfg_num_sig;
                duty_act_d = cfg_duty_sig;
            end else begin
                num_act_d  = num_act_q;
            end
        end else if (wrap_s) begin
            // Boundary: a shadowed config loads here; an offer arriving on
            // this very cycle (only possible with nothing pending) skips the
            // shadow and governs the next period directly.
            if (pend_q) begin
                num_act_d  = shd_num_q;
                duty_act_d = shd_duty_q;
                shd_num_d  = {CNT_W{1'b0}};
                shd_duty_d = {CNT_W{1'b0}};
                pend_d     = 1'b0;
            end else if (xfer_s && legal_s) begin
                num_act_d  = cfg_num_sig;
                duty_act_d = cfg_duty_sig;
            end else begin
                pend_d     = 1'b0;
            end
        end else begin
            // Mid-period: park the config until the next boundary.
            if (xfer_s && legal_s) begin
                shd_num_d  = cfg_num_sig;
                shd_duty_d = cfg_duty_sig;
                pend_d     = 1'b1;
            end else begin
                pend_d     = pend_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (en_sig) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_PEND, ST_STOP: begin
                // Dropping en_sig on the final cycle of a period ends straight
                // away; otherwise the period is finished in STOP. Re-asserting
                // en_sig before the wrap resumes without a gap.
                if (!en_sig) begin
                    if (wrap_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (pend_d) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, active/shadow config and registered outputs.
    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            state_q    <= ST_IDLE;
            num_act_q  <= CNT_W'(DEF_NUM);
            duty_act_q <= CNT_W'(DEF_DUTY);
            shd_num_q  <= {CNT_W{1'b0}};
            shd_duty_q <= {CNT_W{1'b0}};
            pend_q     <= 1'b0;
            div_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_act_q  <= num_act_d;
            duty_act_q <= duty_act_d;
            shd_num_q  <= shd_num_d;
            shd_duty_q <= shd_duty_d;
            pend_q     <= pend_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready_sig  = !pend_q;
    assign div_sig        = div_q;
    assign tick_sig       = tick_q;
    assign cfg_err_sig    = err_q;
    assign pend_sig       = pend_q;
    assign active_num_sig = num_act_q;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Directed bench for div_ctrl. Inputs change 1 time unit after a rising edge
// and outputs are read at the same point, i.e. they reflect the edge just
// taken. Expected waveforms come from the divider definition: at period
// phase k, div = (k < duty) and tick = (k == 0).
// -----------------------------------------------------------------------------
module tb_div_ctrl;
    localparam int CNT_W = 8;

    logic             clk_sig;
    logic             reset_sig;
    logic             en_sig;
    logic             cfg_valid_sig;
    logic             cfg_ready_sig;
    logic [CNT_W-1:0] cfg_num_sig;
    logic [CNT_W-1:0] cfg_duty_sig;
    logic             div_sig;
    logic             tick_sig;
    logic             cfg_err_sig;
    logic             pend_sig;
    logic [CNT_W-1:0] active_num_sig;

    int n_checks;
    int n_pass;

    div_ctrl #(.CNT_W(CNT_W), .DEF_NUM(4), .DEF_DUTY(2)) dut (
        .clk_sig        (clk_sig),
        .reset_sig      (reset_sig),
        .en_sig         (en_sig),
        .cfg_valid_sig  (cfg_valid_sig),
        .cfg_ready_sig  (cfg_ready_sig),
        .cfg_num_sig    (cfg_num_sig),
        .cfg_duty_sig   (cfg_duty_sig),
        .div_sig        (div_sig),
        .tick_sig       (tick_sig),
        .cfg_err_sig    (cfg_err_sig),
        .pend_sig       (pend_sig),
        .active_num_sig (active_num_sig)
    );

    initial clk_sig = 1'b0;
    always #5 clk_sig = ~clk_sig;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_sig);
        #1;
    endtask

    // Compare div/tick against the phase-k value of a num/duty waveform.
    task automatic chk_phase(input string tag, input int k, input int num, input int duty);
        int ph;
        ph = k % num;
        check_eq({tag, ".div"},  32'(div_sig),  (ph < duty) ? 32'd1 : 32'd0);
        check_eq({tag, ".tick"}, 32'(tick_sig), (ph == 0)   ? 32'd1 : 32'd0);
    endtask

    task automatic chk_idle_out(input string tag);
        check_eq({tag, ".div"},  32'(div_sig),  32'd0);
        check_eq({tag, ".tick"}, 32'(tick_sig), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_idle_out(tag);
        check_eq({tag, ".err"},   32'(cfg_err_sig),    32'd0);
        check_eq({tag, ".pend"},  32'(pend_sig),       32'd0);
        check_eq({tag, ".ready"}, 32'(cfg_ready_sig),  32'd1);
        check_eq({tag, ".num"},   32'(active_num_sig), 32'd4);
    endtask

    task automatic do_reset();
        reset_sig     = 1'b1;
        en_sig        = 1'b0;
        cfg_valid_sig = 1'b0;
        cfg_num_sig   = 8'd0;
        cfg_duty_sig  = 8'd0;
        step();
        step();
        reset_sig = 1'b0;
    endtask

    task automatic offer(input int num, input int duty);
        cfg_valid_sig = 1'b1;
        cfg_num_sig   = 8'(num);
        cfg_duty_sig  = 8'(duty);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // 1: reset state and default 4/2 waveform.
        do_reset();
        chk_reset_vals("rst");
        en_sig = 1'b1;
        step();
        chk_idle_out("t1.first");
        for (int k = 0; k < 8; k++) begin
            step();
            chk_phase("t1.def", k, 4, 2);
        end

        // 2: config in IDLE applies next cycle without pending.
        do_reset();
        offer(6, 3);
        step();
        cfg_valid_sig = 1'b0;
        check_eq("t2.num",  32'(active_num_sig), 32'd6);
        check_eq("t2.pend", 32'(pend_sig),       32'd0);
        en_sig = 1'b1;
        step();
        chk_idle_out("t2.first");
        for (int k = 0; k < 12; k++) begin
            step();
            chk_phase("t2.r63", k, 6, 3);
        end

        // 3: mid-period config waits for the wrap.
        do_reset();
        en_sig = 1'b1;
        step();
        step();
        chk_phase("t3.p0", 0, 4, 2);
        check_eq("t3.rdy0", 32'(cfg_ready_sig), 32'd1);
        offer(10, 1);
        step();
        cfg_valid_sig = 1'b0;
        chk_phase("t3.p1", 1, 4, 2);
        check_eq("t3.pend1", 32'(pend_sig),       32'd1);
        check_eq("t3.rdy1",  32'(cfg_ready_sig),  32'd0);
        check_eq("t3.num1",  32'(active_num_sig), 32'd4);
        step();
        chk_phase("t3.p2", 2, 4, 2);
        check_eq("t3.pend2", 32'(pend_sig), 32'd1);
        step();
        chk_phase("t3.p3", 3, 4, 2);
        check_eq("t3.pend3", 32'(pend_sig),       32'd0);
        check_eq("t3.rdy3",  32'(cfg_ready_sig),  32'd1);
        check_eq("t3.num3",  32'(active_num_sig), 32'd10);
        for (int k = 0; k < 10; k++) begin
            step();
            chk_phase("t3.r101", k, 10, 1);
        end

        // 4: illegal configs pulse cfg_err_sig and change nothing.
        do_reset();
        en_sig = 1'b1;
        step();
        step();
        offer(1, 1);
        step();
        cfg_valid_sig = 1'b0;
        check_eq("t4.err1", 32'(cfg_err_sig),   32'd1);
        check_eq("t4.rdy1", 32'(cfg_ready_sig), 32'd1);
        chk_phase("t4.p1", 1, 4, 2);
        step();
        check_eq("t4.err1b", 32'(cfg_err_sig), 32'd0);
        chk_phase("t4.p2", 2, 4, 2);
        offer(4, 5);
        step();
        cfg_valid_sig = 1'b0;
        check_eq("t4.err2", 32'(cfg_err_sig), 32'd1);
        chk_phase("t4.p3", 3, 4, 2);
        step();
        check_eq("t4.err2b", 32'(cfg_err_sig),    32'd0);
        check_eq("t4.num",   32'(active_num_sig), 32'd4);
        check_eq("t4.pend",  32'(pend_sig),       32'd0);
        chk_phase("t4.p4", 4, 4, 2);

        // 5a: en drops at cnt=1 -> period completes, then idle.
        do_reset();
        en_sig = 1'b1;
        step();
        step();
        en_sig = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk_phase("t5.tail", k, 4, 2);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle_out("t5.idle");
        end

        // 5b: config accepted as en drops -> applied at final wrap, then idle.
        do_reset();
        en_sig = 1'b1;
        step();
        step();
        offer(6, 3);
        en_sig = 1'b0;
        step();
        cfg_valid_sig = 1'b0;
        check_eq("t5b.pend", 32'(pend_sig), 32'd1);
        step();
        step();
        chk_phase("t5b.p3", 3, 4, 2);
        check_eq("t5b.num",   32'(active_num_sig), 32'd6);
        check_eq("t5b.pend2", 32'(pend_sig),       32'd0);
        step();
        chk_idle_out("t5b.idle");

        // 5c: reset while pending discards the shadow config.
        do_reset();
        en_sig = 1'b1;
        step();
        step();
        offer(10, 1);
        step();
        cfg_valid_sig = 1'b0;
        check_eq("t5c.pend", 32'(pend_sig), 32'd1);
        reset_sig = 1'b1;
        step();
        reset_sig = 1'b0;
        chk_reset_vals("t5c.rst");
        step();
        chk_idle_out("t5c.first");
        for (int k = 0; k < 8; k++) begin
            step();
            chk_phase("t5c.def", k, 4, 2);
        end
        check_eq("t5c.num", 32'(active_num_sig), 32'd4);

        // 6: duty=0 run, then duty=num=5 offered on the wrap cycle (bypass).
        do_reset();
        offer(5, 0);
        step();
        cfg_valid_sig = 1'b0;
        en_sig = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk_phase("t6.d0", k, 5, 0);
        end
        offer(5, 5);
        step();
        cfg_valid_sig = 1'b0;
        chk_phase("t6.d0w", 4, 5, 0);
        check_eq("t6.pend", 32'(pend_sig),       32'd0);
        check_eq("t6.num",  32'(active_num_sig), 32'd5);
        for (int k = 0; k < 10; k++) begin
            step();
            chk_phase("t6.d5", k, 5, 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
